// File: rtl/timer_counter.sv
// ---------------------------------------------------------------------------
// timer_counter
//
// Memory-mapped programmable down-counter timer.  Software programs PRESET
// and CTRL through the data-memory bridge; the block loads PRESET into COUNT,
// counts down to zero and raises an interrupt towards CP0 hwint[0].
//
//   Mode 0 (and reserved modes 2/3): one-shot, level interrupt held until a
//                                    CTRL or PRESET write clears it.
//   Mode 1                         : auto-reload, one-cycle pulse per period.
//
// Register map (word offset on i_addr):
//   0 CTRL   : bit0 Enable, bits2:1 Mode, bit3 IM (1 = irq passes); rest reads 0
//   1 PRESET : read/write, COUNT_W bits, zero-extended on read
//   2 COUNT  : read-only, writes ignored
//   3 -      : reserved, reads 0, writes ignored
//
// Ports:
//   i_clk    : system clock, all state updates on the rising edge
//   i_reset  : synchronous active-high reset
//   i_we     : register write strobe from the bridge
//   i_addr   : register select (word offset)
//   i_wdata  : write data
//   o_rdata  : read data, combinational on i_addr
//   o_irq    : interrupt request (irq flag gated by CTRL.IM)
// ---------------------------------------------------------------------------
module timer_counter #(
   parameter int COUNT_W = 32
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_we,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_irq
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_t;

   state_t               r_state;
   logic                 r_enable;
   logic [1:0]           r_mode;
   logic                 r_im;
   logic [COUNT_W-1:0]   r_preset;
   logic [COUNT_W-1:0]   r_count;
   logic                 r_irq_flag;
   logic [31:0]          w_rdata;

   // Register file and timer FSM.  A bus write takes priority for the whole
   // cycle: the addressed register updates and the FSM/COUNT hold, so
   // software and the sequencer never modify CTRL in the same cycle.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_enable   <= 1'b0;
         r_mode     <= 2'b00;
         r_im       <= 1'b0;
         r_preset   <= '0;
         r_count    <= '0;
         r_irq_flag <= 1'b0;
      end else if (i_we) begin
         case (i_addr)
            2'd0: begin
               r_enable   <= i_wdata[0];
               r_mode     <= i_wdata[2:1];
               r_im       <= i_wdata[3];
               r_irq_flag <= 1'b0;
            end
            2'd1: begin
               r_preset   <= i_wdata[COUNT_W-1:0];
               r_irq_flag <= 1'b0;
            end
            default: begin
               // COUNT is read-only and offset 3 is reserved: nothing changes.
               r_state <= r_state;
            end
         endcase
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (r_enable) begin
                  r_state <= ST_LOAD;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_LOAD: begin
               r_count <= r_preset;
               r_state <= ST_CNT;
            end
            ST_CNT: begin
               if (!r_enable) begin
                  // Disabled mid-count: COUNT freezes where it is.
                  r_state <= ST_IDLE;
               end else if (r_count > COUNT_W'(1)) begin
                  r_count <= r_count - COUNT_W'(1);
               end else begin
                  // Expiry on 1 (or a PRESET of 0) so the decrement never wraps.
                  r_count    <= '0;
                  r_irq_flag <= 1'b1;
                  r_state    <= ST_INT;
               end
            end
            ST_INT: begin
               r_state <= ST_IDLE;
               if (r_mode == 2'd1) begin
                  // Auto-reload: Enable stays set so IDLE goes straight to LOAD.
                  r_irq_flag <= 1'b0;
               end else begin
                  // One-shot: stop, keep the level irq for software to clear.
                  r_enable <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Read-data mux; PRESET/COUNT are zero-extended to the bus width.
   always_comb begin
      w_rdata = 32'd0;
      case (i_addr)
         2'd0: begin
            w_rdata[3:0] = {r_im, r_mode, r_enable};
         end
         2'd1: begin
            w_rdata[COUNT_W-1:0] = r_preset;
         end
         2'd2: begin
            w_rdata[COUNT_W-1:0] = r_count;
         end
         default: begin
            w_rdata = 32'd0;
         end
      endcase
   end

   assign o_rdata = w_rdata;
   assign o_irq   = r_irq_flag & r_im;

endmodule

// File: tb/tb_timer_counter.sv
// ---------------------------------------------------------------------------
// tb_timer_counter
//
// Directed, table-driven bench for timer_counter.  Each table record drives
// one clock cycle (reset, write strobe, address, write data) and gives the
// rdata (at the same address) and irq expected just after that edge.  A
// hand-written sequence measures the mode-1 pulse period.
// ---------------------------------------------------------------------------
module tb_timer_counter;

   logic        clk;
   logic        reset;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int checks;
   int failures;

   typedef struct {
      logic        rst;
      logic        we;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[$];

   timer_counter #(.COUNT_W(32)) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .i_we    (we),
      .i_addr  (addr),
      .i_wdata (wdata),
      .o_rdata (rdata),
      .o_irq   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic r, input logic w, input logic [1:0] a,
                      input logic [31:0] d, input logic [31:0] er, input logic ei);
      vec_t v;
      v.rst = r; v.we = w; v.addr = a; v.wdata = d;
      v.exp_rdata = er; v.exp_irq = ei;
      vecs.push_back(v);
   endtask

   // Drive one cycle, then sample 1 time unit after the rising edge.
   task automatic step(input logic r, input logic w, input logic [1:0] a,
                       input logic [31:0] d);
      reset = r; we = w; addr = a; wdata = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b1; we = 1'b0; addr = 2'd0; wdata = 32'd0;

      // Reset held 2 cycles, then all registers read 0.
      add(1'b1, 1'b0, 2'd0, 32'd0,   32'd0, 1'b0);
      add(1'b1, 1'b0, 2'd1, 32'd0,   32'd0, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd0, 1'b0);

      // Mode 0 one-shot, PRESET=5; irq after edge 7 from the CTRL write.
      add(1'b0, 1'b1, 2'd1, 32'd5,   32'd5, 1'b0);
      add(1'b0, 1'b1, 2'd0, 32'h9,   32'h9, 1'b0);   // E0
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd0, 1'b0);   // E1 IDLE->LOAD
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd5, 1'b0);   // E2 LOAD
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd4, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd3, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd2, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd1, 1'b0);   // E6
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd0, 1'b1);   // E7 expiry
      add(1'b0, 1'b0, 2'd0, 32'd0,   32'h8, 1'b1);   // E8 Enable cleared
      add(1'b0, 1'b0, 2'd0, 32'd0,   32'h8, 1'b1);   // level holds
      add(1'b0, 1'b1, 2'd0, 32'h8,   32'h8, 1'b0);   // ack clears flag
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd0, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd0, 1'b0);

      // Disable mid-count at COUNT=6, then re-enable reloads PRESET=10.
      add(1'b1, 1'b0, 2'd0, 32'd0,   32'd0, 1'b0);
      add(1'b0, 1'b1, 2'd1, 32'd10,  32'd10, 1'b0);
      add(1'b0, 1'b1, 2'd0, 32'h9,   32'h9, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd0, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd10, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd9, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd8, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd7, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd6, 1'b0);
      add(1'b0, 1'b1, 2'd0, 32'h8,   32'h8, 1'b0);   // disable (write holds FSM)
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd6, 1'b0);   // CNT->IDLE, frozen
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd6, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd6, 1'b0);
      add(1'b0, 1'b1, 2'd0, 32'h9,   32'h9, 1'b0);   // re-enable
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd6, 1'b0);   // IDLE->LOAD
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd10, 1'b0);  // reloaded
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd9, 1'b0);

      // Masked expiry and ignored writes to COUNT / reserved.
      add(1'b1, 1'b0, 2'd0, 32'd0,   32'd0, 1'b0);
      add(1'b0, 1'b1, 2'd1, 32'd2,   32'd2, 1'b0);
      add(1'b0, 1'b1, 2'd0, 32'h1,   32'h1, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd0, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd2, 1'b0);
      add(1'b0, 1'b1, 2'd2, 32'h1234, 32'd2, 1'b0);  // COUNT write ignored
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd1, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd0, 1'b0);   // expiry, masked
      add(1'b0, 1'b0, 2'd0, 32'd0,   32'h0, 1'b0);
      add(1'b0, 1'b1, 2'd3, 32'hFFFF, 32'd0, 1'b0);  // reserved
      add(1'b0, 1'b0, 2'd1, 32'd0,   32'd2, 1'b0);

      // PRESET=0 behaves as 1: irq after edge 3.
      add(1'b1, 1'b0, 2'd0, 32'd0,   32'd0, 1'b0);
      add(1'b0, 1'b1, 2'd1, 32'd0,   32'd0, 1'b0);
      add(1'b0, 1'b1, 2'd0, 32'h9,   32'h9, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd0, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd0, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd0, 1'b1);
      add(1'b0, 1'b0, 2'd0, 32'd0,   32'h8, 1'b1);

      // PRESET rewritten mid-count does not disturb the running COUNT.
      add(1'b1, 1'b0, 2'd0, 32'd0,   32'd0, 1'b0);
      add(1'b0, 1'b1, 2'd1, 32'd4,   32'd4, 1'b0);
      add(1'b0, 1'b1, 2'd0, 32'h9,   32'h9, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd0, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd4, 1'b0);
      add(1'b0, 1'b1, 2'd1, 32'd7,   32'd7, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd3, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd2, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd1, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd0, 1'b1);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd0, 1'b1);
      add(1'b0, 1'b1, 2'd1, 32'd7,   32'd7, 1'b0);   // PRESET write clears flag

      // Reset mid-operation in mode 1 while COUNT=4.
      add(1'b1, 1'b0, 2'd0, 32'd0,   32'd0, 1'b0);
      add(1'b0, 1'b1, 2'd1, 32'd5,   32'd5, 1'b0);
      add(1'b0, 1'b1, 2'd0, 32'hB,   32'hB, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd0, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd5, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd4, 1'b0);
      add(1'b1, 1'b0, 2'd2, 32'd0,   32'd0, 1'b0);
      add(1'b0, 1'b0, 2'd0, 32'd0,   32'd0, 1'b0);
      add(1'b0, 1'b0, 2'd1, 32'd0,   32'd0, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd0, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd0, 1'b0);
      add(1'b0, 1'b0, 2'd2, 32'd0,   32'd0, 1'b0);

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].wdata);
         chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
         chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
      end

      // Mode 1, PRESET=3: single-cycle pulses at edges 5, 11, 17 after CTRL write.
      step(1'b1, 1'b0, 2'd0, 32'd0);
      step(1'b0, 1'b1, 2'd1, 32'd3);
      step(1'b0, 1'b1, 2'd0, 32'hB);
      for (int k = 1; k <= 18; k++) begin
         logic exp_p;
         step(1'b0, 1'b0, 2'd0, 32'd0);
         exp_p = (k == 5) || (k == 11) || (k == 17);
         chk($sformatf("mode1_irq_edge%0d", k), {31'd0, irq}, {31'd0, exp_p});
      end
      chk("mode1_ctrl_kept", rdata, 32'hB);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
Memory-mapped programmable down-counter timer that raises a hardware interrupt line into the coprocessor-0 interrupt inputs (hwint[0]).
Software programs PRESET and CTRL through the data-memory bridge. The block loads, counts down and signals expiry.
Mode 0 is one-shot with a level interrupt held until software acknowledges it. Mode 1 is auto-reload with a one-cycle interrupt pulse per period.

Parameters:
COUNT_W, 32, width of PRESET and COUNT registers; wider read/write data is truncated on write and zero-extended on read.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
we  input  1  register write strobe from bridge
addr  input  2  register select (word offset: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved)
wdata  input  32  write data
rdata  output  32  read data, combinational on addr
irq  output  1  interrupt request to CP0 hwint[0]

Behaviour:
- Registers:
  - CTRL[3:0]: bit0 Enable, bits2:1 Mode, bit3 IM (interrupt mask, 1 = pass). CTRL[31:4] reads 0.
  - PRESET: read/write.
  - COUNT: read-only; a write to COUNT or to addr 3 is ignored.
- rdata by addr: 0 {28'b0, CTRL}; 1 PRESET; 2 COUNT; 3 0.
- Reset: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, irq=0.
- irq = irq_flag & CTRL.IM.
- Write cycle (we=1):
  - The addressed register updates at the edge.
  - The FSM holds: no state change, no COUNT change.
  - Any write to CTRL or PRESET clears irq_flag.
- FSM, in non-write cycles:
  - IDLE: Enable=1 -> LOAD; else stay.
  - LOAD: COUNT<=PRESET; -> CNT. LOAD is unconditional.
  - CNT:
    - Enable=0 -> IDLE, COUNT holds its value.
    - Else if COUNT>1: COUNT<=COUNT-1.
    - Else (COUNT<=1): COUNT<=0, irq_flag<=1, -> INT.
  - INT:
    - Mode 0 (and reserved modes 2, 3): CTRL.Enable<=0, -> IDLE; irq_flag stays 1 until a CTRL/PRESET write.
    - Mode 1: -> IDLE, irq_flag<=0 (one-cycle pulse); Enable stays 1, so the timer reloads.
- Latency: with PRESET=N>=1, irq_flag is visible after edge N+2 counted from the write edge that sets Enable.
  - Mode 1 period is N+3 cycles between irq pulses.
- PRESET=0 behaves as PRESET=1: expiry after one CNT cycle, COUNT reads 0.
- Writing PRESET mid-count does not affect the current COUNT; it takes effect at the next LOAD.
- IM=0 masks irq only; irq_flag still sets. Unmasking requires a CTRL write, which clears the flag, so a masked expiry is lost by design.
- Reset mid-count: returns to reset values at the next edge, irq deasserts immediately after that edge.
- Arithmetic: COUNT decrements modulo 2^COUNT_W. Wrap never occurs because of the <=1 check.

Test Plan:
- Reset check: reset held 2 cycles -> rdata=0 at addr 0, 1 and 2; irq=0.
- Mode 0 one-shot: write PRESET=5, then CTRL=0x9 (Enable, mode 0, IM) -> COUNT reads 5,4,3,2,1,0; irq rises 7 edges after the CTRL write edge and stays high; CTRL reads 0x8. Writing CTRL=0x8 -> irq falls next cycle; COUNT stays 0; FSM stays IDLE.
- Mode 1 auto-reload: PRESET=3, CTRL=0xB -> irq is a single-cycle pulse repeating every 6 cycles; CTRL stays 0xB.
- Disable mid-count: mode 0, PRESET=10; after COUNT reads 6, write CTRL=0x8 -> COUNT freezes at 6, no irq. Rewrite CTRL=0x9 -> reload to 10 and count again.
- Mask and ignored writes: CTRL=0x1 (IM=0), PRESET=2 -> irq stays 0 through expiry. A write to addr 2 with 0x1234 -> COUNT unchanged, addr 3 reads 0.
- Reset mid-operation: assert reset while COUNT=4 in mode 1 -> all registers 0, irq 0, and no further counting after reset drops.
